ibuffer_issue_arb: RTL

Round-robin issue arbiter between the per-warp instruction buffers and the single issue path to the scoreboard and operand collector. Each cycle it selects one eligible warp buffer (valid and not blocked by a hazard) and registers its decoded instruction into a one-entry output stage. It fully handshakes on both sides and sustains one instruction per cycle.

---
 rtl/ibuffer_issue_arb_if.sv | 27 ++
 rtl/ibuffer_issue_arb.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ibuffer_issue_arb_if.sv
// Handshake bundle between the warp instruction buffers, the issue arbiter and the issue stage.
// master = buffers/downstream side, slave = arbiter side.
interface ibuffer_issue_arb_if #(
   parameter int NUM_REQS   = 4,
   parameter int DATA_WIDTH = 128
);
   localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

   logic [NUM_REQS-1:0]            req_valid;
   logic [NUM_REQS*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQS-1:0]            req_ready;
   logic [NUM_REQS-1:0]            req_block;
   logic                           out_valid;
   logic [DATA_WIDTH-1:0]          out_data;
   logic [IDX_W-1:0]               out_idx;
   logic                           out_ready;

   modport master (
      output req_valid, req_data, req_block, out_ready,
      input  req_ready, out_valid, out_data, out_idx
   );

   modport slave (
      input  req_valid, req_data, req_block, out_ready,
      output req_ready, out_valid, out_data, out_idx
   );
endinterface

// File: rtl/ibuffer_issue_arb.sv
// Round-robin issue arbiter: picks one eligible warp buffer per cycle into a one-entry output stage.
// Define IBUF_ARB_PERF_EN to build the perf_issued / perf_stalls counters.
module ibuffer_issue_arb #(
   parameter int NUM_REQS   = 4,
   parameter int DATA_WIDTH = 128
) (
   input  logic                   clk,
   input  logic                   reset_n,
   ibuffer_issue_arb_if.slave     bus
`ifdef IBUF_ARB_PERF_EN
   ,
   output logic [31:0]            perf_issued,
   output logic [31:0]            perf_stalls
`endif
);
   localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

   logic [NUM_REQS-1:0]   eligible_s;
   logic                  load_en_s;
   logic [NUM_REQS-1:0]   grant_s;
   logic [IDX_W-1:0]      grant_idx_s;
   logic                  found_s;
   logic [NUM_REQS-1:0]   shifted_s;
   int                    cand_s;
   logic [DATA_WIDTH-1:0] sel_data_s;
   logic [IDX_W-1:0]      rr_next_s;

   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [IDX_W-1:0]      out_idx_q;
   logic [IDX_W-1:0]      rr_ptr_q;

   assign eligible_s = bus.req_valid & ~bus.req_block;
   assign load_en_s  = ~out_valid_q | bus.out_ready;

   // Rotating scan from rr_ptr; the modulo is done by subtraction so any NUM_REQS works.
   always_comb begin
      found_s     = 1'b0;
      grant_idx_s = '0;
      cand_s      = 0;
      shifted_s   = '0;
      for (int k = 0; k < NUM_REQS; k++) begin
         cand_s = int'(rr_ptr_q) + k;
         if (cand_s >= NUM_REQS) begin
            cand_s = cand_s - NUM_REQS;
         end else begin
            cand_s = cand_s;
         end
         shifted_s = eligible_s >> cand_s;
         if (!found_s && shifted_s[0]) begin
            found_s     = 1'b1;
            grant_idx_s = IDX_W'(cand_s);
         end else begin
            found_s     = found_s;
         end
      end
   end

   // One-hot grant, granted record and pointer successor.
   always_comb begin
      grant_s    = '0;
      sel_data_s = '0;
      rr_next_s  = '0;
      if (found_s) begin
         grant_s = NUM_REQS'(1'b1) << grant_idx_s;
      end else begin
         grant_s = '0;
      end
      for (int j = 0; j < NUM_REQS; j++) begin
         if (grant_s[j]) begin
            sel_data_s = bus.req_data[j*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            sel_data_s = sel_data_s;
         end
      end
      if (grant_idx_s == IDX_W'(NUM_REQS - 1)) begin
         rr_next_s = '0;
      end else begin
         rr_next_s = grant_idx_s + IDX_W'(1'b1);
      end
   end

   // Pop strobe is suppressed while reset is held so no buffer loses an entry.
   assign bus.req_ready = (load_en_s && reset_n) ? grant_s : '0;

   // Output stage and round-robin pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         rr_ptr_q    <= '0;
      end else if (load_en_s) begin
         if (found_s) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data_s;
            out_idx_q   <= grant_idx_s;
            rr_ptr_q    <= rr_next_s;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else begin
         out_valid_q <= out_valid_q;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_idx   = out_idx_q;

`ifdef IBUF_ARB_PERF_EN
   logic [31:0] issued_q;
   logic [31:0] stalls_q;

   // Issue and back-pressure counters; both wrap naturally at 2^32.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         issued_q <= 32'd0;
         stalls_q <= 32'd0;
      end else if (out_valid_q) begin
         if (bus.out_ready) begin
            issued_q <= issued_q + 32'd1;
         end else begin
            stalls_q <= stalls_q + 32'd1;
         end
      end else begin
         issued_q <= issued_q;
      end
   end

   assign perf_issued = issued_q;
   assign perf_stalls = stalls_q;
`endif
endmodule
